if_fetch: RTL



---
 rtl/if_fetch_pkg.sv | 21 ++
 rtl/if_fetch.sv | 110 +++++++++++
 2 files changed

// File: rtl/if_fetch_pkg.sv
// Shared pipeline definitions: fetch FSM states, datapath widths and the
// common reset PC used by the fetch stage, IF/ID register and branch unit.
package if_fetch_pkg;

    localparam int                 INSTR_W          = 32;
    localparam logic [INSTR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } fetch_state_e;

    // Instructions are word aligned; low address bits are never meaningful.
    function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] addr);
        return addr & ~(INSTR_W'(3));
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and holds each returned word in a one-entry buffer.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jump,
    input  logic [INSTR_W-1:0] jump_addr,
    input  logic               stall,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] out_instr,
    output logic [INSTR_W-1:0] out_pc,
    output logic               out_valid
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [INSTR_W-1:0] out_pc_q, out_pc_d;
    logic               out_valid_q, out_valid_d;
    logic               issue;

    // A new request is only sent when the buffer will be free to take its reply.
    assign issue = (state_q == ST_REQ) && !jump && (!out_valid_q || !stall);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave a signal unassigned (latch).
        state_d     = state_q;
        pc_d        = pc_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && !stall) begin
            out_valid_d = 1'b0;
        end

        if (jump) begin
            pc_d        = align_pc(jump_addr);
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (issue) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (jump) begin
                    // A reply arriving with the redirect is simply dropped.
                    state_d = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid) begin
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_q + PC_STEP;
                    state_d     = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before this edge.
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign out_valid = out_valid_q;

    // Memory only answers a request, so a reply can never show up before one is sent.
    a_rvalid_legal: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> (state_q == ST_WAIT || state_q == ST_DROP));

endmodule
